// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int RF_MAX_READ_PORTS = 4;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by long-latency issue, cleared by the producing write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REGISTERS   = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  localparam int AW         = rf_aw(REGISTERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        sb_set,
  input  logic [AW-1:0]               sb_addr,
  input  logic [WRITE_PORTS-1:0]      we,
  input  logic [WRITE_PORTS*AW-1:0]   wa,
  input  logic [READ_PORTS*AW-1:0]    ra,
  output logic [READ_PORTS-1:0]       rd_pending
);

  logic [REGISTERS-1:0] pend_q, pend_d;

  // Set is applied after the write clears so a new producer supersedes the retiring one.
  always_comb begin
    pend_d = pend_q;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (we[p]) pend_d[wa[p*AW +: AW]] = 1'b0;
    end
    if (sb_set) pend_d[sb_addr] = 1'b1;
    if (clear) pend_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar r = 0; r < READ_PORTS; r++) begin : g_lookup
    logic [AW-1:0] a;
    assign a = ra[r*AW +: AW];
    assign rd_pending[r] = (ZERO_REG != 0 && a == '0) ? 1'b0 : pend_q[a];
  end

endmodule

// File: rtl/multiport_register_file.sv
// N-read/M-write register file with clear sequencer, write bypass, zero register and scoreboard.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int REGISTERS   = 32,
  parameter int WIDTH       = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  localparam int AW         = rf_aw(REGISTERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_req,
  output logic                          ready,
  input  logic [WRITE_PORTS-1:0]        we,
  input  logic [WRITE_PORTS*AW-1:0]     wa,
  input  logic [WRITE_PORTS*WIDTH-1:0]  wd,
  input  logic [READ_PORTS*AW-1:0]      ra,
  output logic [READ_PORTS*WIDTH-1:0]   rd,
  output logic [READ_PORTS-1:0]         rd_pending,
  input  logic                          sb_set,
  input  logic [AW-1:0]                 sb_addr,
  output logic                          write_conflict
);

  rf_state_t         state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              write_conflict_q, write_conflict_d;
  logic [WIDTH-1:0]  regs_q [REGISTERS];
  logic [AW-1:0]     wa_a [WRITE_PORTS];
  logic [WIDTH-1:0]  wd_a [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] we_acc;
  logic [READ_PORTS-1:0]  pend_raw;

  for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_wsplit
    assign wa_a[p] = wa[p*AW +: AW];
    assign wd_a[p] = wd[p*WIDTH +: WIDTH];
  end

  assign ready  = (state_q == RF_READY);
  // A clear request takes the edge, so same-cycle writes are not accepted.
  assign we_acc = we & {WRITE_PORTS{ready && !clear_req}};

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      RF_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(REGISTERS - 1)) state_d = RF_READY;
      end
      RF_READY: begin
        if (clear_req) begin
          state_d   = RF_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  always_comb begin
    write_conflict_d = 1'b0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      for (int q = p + 1; q < WRITE_PORTS; q++) begin
        if (we_acc[p] && we_acc[q] && wa_a[p] == wa_a[q]) write_conflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= RF_CLEAR;
      clr_cnt_q        <= '0;
      write_conflict_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      clr_cnt_q        <= clr_cnt_d;
      write_conflict_q <= write_conflict_d;
    end
  end

  assign write_conflict = write_conflict_q;

  // Storage is initialised by the clear sequencer rather than by reset.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) begin
      regs_q[clr_cnt_q] <= '0;
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (we_acc[p] && !(ZERO_REG != 0 && wa_a[p] == '0)) regs_q[wa_a[p]] <= wd_a[p];
      end
    end
  end

  for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] rdat;
    assign a = ra[r*AW +: AW];
    always_comb begin
      rdat = regs_q[a];
      if (BYPASS != 0) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (we[p] && wa_a[p] == a) rdat = wd_a[p];
        end
      end
      if (!ready || (ZERO_REG != 0 && a == '0)) rdat = '0;
    end
    assign rd[r*WIDTH +: WIDTH] = rdat;
  end

  regfile_scoreboard #(
    .REGISTERS   (REGISTERS),
    .READ_PORTS  (READ_PORTS),
    .WRITE_PORTS (WRITE_PORTS),
    .ZERO_REG    (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .clear      (ready && clear_req),
    .sb_set     (sb_set && ready),
    .sb_addr    (sb_addr),
    .we         (we_acc),
    .wa         (wa),
    .ra         (ra),
    .rd_pending (pend_raw)
  );

  assign rd_pending = pend_raw & {READ_PORTS{ready}};

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: 32x32 2R/2W file, bypass and non-bypass instances driven in parallel.
module tb_multiport_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic        ready, ready_nb;
  logic [63:0] rd, rd_nb;
  logic [1:0]  rd_pending, rd_pending_nb;
  logic        write_conflict, write_conflict_nb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiport_register_file #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd), .rd_pending(rd_pending),
    .sb_set(sb_set), .sb_addr(sb_addr), .write_conflict(write_conflict)
  );

  multiport_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_nb),
    .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb), .rd_pending(rd_pending_nb),
    .sb_set(sb_set), .sb_addr(sb_addr), .write_conflict(write_conflict_nb)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [31:0] exp_nb0;
    logic        exp_wc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 2'b00; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0; clear_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 31) begin
        chk({tag, " ready@31"}, {31'd0, ready}, 32'd0);
        chk({tag, " nb ready@31"}, {31'd0, ready_nb}, 32'd0);
      end
      if (i == 32) begin
        chk({tag, " ready@32"}, {31'd0, ready}, 32'd1);
        chk({tag, " nb ready@32"}, {31'd0, ready_nb}, 32'd1);
      end
    end
  endtask

  initial begin
    //            we     wa0    wd0            wa1    wd1            ra0    ra1    rd0            rd1            nb0            wc
    vecs[0]  = '{2'b01, 5'd7,  32'h12345678, 5'd0,  32'h0,        5'd7,  5'd8,  32'h12345678, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 1'b0};
    vecs[2]  = '{2'b11, 5'd9,  32'hA,        5'd9,  32'hB,        5'd9,  5'd7,  32'hB,        32'h12345678, 32'h0,        1'b0};
    vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd9,  32'hB,        32'hB,        32'hB,        1'b1};
    vecs[4]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd0,  32'hB,        32'h0,        32'hB,        1'b0};
    vecs[5]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b0};
    vecs[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd9,  32'h0,        32'hB,        32'h0,        1'b0};
    vecs[7]  = '{2'b11, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h1,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b0};
    vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd7,  32'h0,        32'h12345678, 32'h0,        1'b1};
    vecs[9]  = '{2'b10, 5'd0,  32'h0,        5'd31, 32'hCAFEBABE, 5'd31, 5'd1,  32'hCAFEBABE, 32'h0,        32'h0,        1'b0};
    vecs[10] = '{2'b11, 5'd1,  32'h11,       5'd2,  32'h22,       5'd1,  5'd2,  32'h11,       32'h22,       32'h0,        1'b0};
    vecs[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd31, 5'd2,  32'hCAFEBABE, 32'h22,       32'hCAFEBABE, 1'b0};

    reset = 1'b1;
    ra = '0;
    idle();
    #1;
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset conflict", {31'd0, write_conflict}, 32'd0);
    chk("reset pending", {30'd0, rd_pending}, 32'd0);

    // Power-up clear interrupted by reset at clr_cnt=10.
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    #1;
    chk("midclear reset ready", {31'd0, ready}, 32'd0);
    step();
    reset = 1'b0;

    // Full clear; a write and a scoreboard set during it must be dropped.
    ra = {5'd3, 5'd2};
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 5) begin
        we = 2'b01; wa = {5'd0, 5'd2}; wd = {32'h0, 32'hDEAD}; sb_set = 1'b1; sb_addr = 5'd3;
        #1;
        chk("clear rd0 zero", rd[31:0], 32'h0);
        chk("clear pending zero", {30'd0, rd_pending}, 32'd0);
      end
      if (i == 6) idle();
      if (i == 31) chk("init ready@31", {31'd0, ready}, 32'd0);
      if (i == 32) chk("init ready@32", {31'd0, ready}, 32'd1);
    end
    #1;
    chk("clear write dropped", rd[31:0], 32'h0);
    chk("clear sb_set dropped", {30'd0, rd_pending}, 32'd0);

    for (int v = 0; v < 12; v++) begin
      we = vecs[v].we;
      wa = {vecs[v].wa1, vecs[v].wa0};
      wd = {vecs[v].wd1, vecs[v].wd0};
      ra = {vecs[v].ra1, vecs[v].ra0};
      #1;
      chk($sformatf("vec%0d rd0", v), rd[31:0], vecs[v].exp_rd0);
      chk($sformatf("vec%0d rd1", v), rd[63:32], vecs[v].exp_rd1);
      chk($sformatf("vec%0d nb rd0", v), rd_nb[31:0], vecs[v].exp_nb0);
      chk($sformatf("vec%0d conflict", v), {31'd0, write_conflict}, {31'd0, vecs[v].exp_wc});
      step();
    end
    idle();

    // Scoreboard: set, clear by write, set beats write on the same edge, zero reg.
    ra = {5'd4, 5'd3};
    sb_set = 1'b1; sb_addr = 5'd3;
    #1;
    chk("sb not bypassed", {30'd0, rd_pending}, 32'd0);
    step();
    idle();
    chk("sb set 3", {30'd0, rd_pending}, 32'd1);
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h5};
    step();
    idle();
    chk("sb write clears", {30'd0, rd_pending}, 32'd0);
    sb_set = 1'b1; sb_addr = 5'd3;
    we = 2'b10; wa = {5'd3, 5'd0}; wd = {32'h6, 32'h0};
    step();
    idle();
    chk("sb set wins", {30'd0, rd_pending}, 32'd1);
    chk("sb write data", rd[31:0], 32'h6);
    ra = {5'd3, 5'd0};
    sb_set = 1'b1; sb_addr = 5'd0;
    step();
    idle();
    chk("sb zero reg", {30'd0, rd_pending}, 32'd2);

    // clear_req in READY: same-edge write dropped, pending cleared, full re-clear.
    ra = {5'd4, 5'd31};
    clear_req = 1'b1;
    we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h77};
    step();
    idle();
    chk("clear_req ready", {31'd0, ready}, 32'd0);
    chk("clear_req rd0", rd[31:0], 32'h0);
    wait_ready("reclear");
    ra = {5'd3, 5'd31};
    #1;
    chk("reclear reg31", rd[31:0], 32'h0);
    chk("reclear nb reg31", rd_nb[31:0], 32'h0);
    chk("reclear pending", {30'd0, rd_pending}, 32'd0);
    ra = {5'd4, 5'd7};
    #1;
    chk("reclear reg7", rd[31:0], 32'h0);
    chk("clear_req write dropped", rd[63:32], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
